// File: rtl/pkwars_chr_fetch_if.sv
// Purpose : groups the fetch requests, returned words and shared CHR-ROM byte port.
// Ports   : BG addr/word, sprite addr/req/word/strobe, ROM addr/read/data.
// slave   : the fetch responder. master : the video generators plus the ROM model.
interface pkwars_chr_fetch_if;
  logic [13:0] BGCAD;   // BG CHR word address
  logic [31:0] BGCDT;   // last completed BG word
  logic [13:0] SPCAD;   // sprite CHR word address
  logic        SPCRQ;   // sprite request, level
  logic [31:0] SPCDT;   // sprite word
  logic        SPCFT;   // one-cycle strobe, SPCDT updated
  logic [16:0] ROMAD;   // {region, word address, byte index}
  logic        ROMRD;   // byte read issued this cycle
  logic [7:0]  ROMDT;   // ROM byte data

  modport slave (
    input  BGCAD, SPCAD, SPCRQ, ROMDT,
    output BGCDT, SPCDT, SPCFT, ROMAD, ROMRD
  );

  modport master (
    output BGCAD, SPCAD, SPCRQ, ROMDT,
    input  BGCDT, SPCDT, SPCFT, ROMAD, ROMRD
  );
endinterface

// File: rtl/pkwars_chr_fetch.sv
// Purpose : serves BG and sprite CHR word fetches from one byte-wide synchronous ROM port.
// Latency : grant to word update is 5+ROMLAT cycles; one word per 6+ROMLAT cycles.
// Backpressure: none on the ROM side; sprite requester holds SPCRQ until SPCFT, BG refetches on address change.
// Ports   : VCLKx4 clock, RESET sync active-low, bus = pkwars_chr_fetch_if.slave.
module pkwars_chr_fetch #(
  parameter int ROMLAT = 1,     // ROM read latency, 1 or 2
  parameter bit FAIR   = 1'b1   // pending sprite takes the slot right after a BG fetch
) (
  input  logic              VCLKx4,
  input  logic              RESET,
  pkwars_chr_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t      state, state_nx;
  logic [1:0]  idx;          // byte index being issued
  logic [1:0]  dcnt;         // drain cycle counter
  logic        region;       // 0 = BG fetch, 1 = sprite fetch
  logic [13:0] bglast;       // BG address latched at the last BG grant
  logic        bgvld;        // bglast holds a real address
  logic        lastbg;       // previous grant went to BG
  logic        bgpend, sppend, grant, grant_sp;
  logic [31:0] asmw;         // word under assembly
  logic [31:0] bgcdt, spcdt;
  logic        spcft, romrd;
  logic [16:0] romad;

  // Read-return tracker: one stage per cycle of ROM latency, carrying the
  // byte index so each returning byte lands in its own lane.
  logic [ROMLAT-1:0]      pvld;
  logic [ROMLAT-1:0][1:0] pidx;

  assign bus.BGCDT = bgcdt;
  assign bus.SPCDT = spcdt;
  assign bus.SPCFT = spcft;
  assign bus.ROMAD = romad;
  assign bus.ROMRD = romrd;

  // Arbitration. Only meaningful in IDLE, where no sprite fetch is in progress.
  always_comb begin
    bgpend   = !bgvld || (bus.BGCAD != bglast);
    sppend   = bus.SPCRQ;
    grant    = (state == IDLE) && (bgpend || sppend);
    grant_sp = 1'b0;
    if (FAIR && lastbg && sppend)
      grant_sp = 1'b1;
    else if (!bgpend && sppend)
      grant_sp = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   if (idx == 2'd3) state_nx = DRAIN;
      DRAIN:   if (dcnt == 2'(ROMLAT - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge VCLKx4) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge VCLKx4) begin
    if (!RESET) begin
      idx    <= 2'd0;
      dcnt   <= 2'd0;
      region <= 1'b0;
      bglast <= 14'd0;
      bgvld  <= 1'b0;
      lastbg <= 1'b0;
      asmw   <= 32'd0;
      bgcdt  <= 32'd0;
      spcdt  <= 32'd0;
      spcft  <= 1'b0;
      romrd  <= 1'b0;
      romad  <= 17'd0;
      pvld   <= '0;
      pidx   <= '0;
    end else begin
      spcft   <= 1'b0;
      pvld[0] <= romrd;
      pidx[0] <= romad[1:0];
      for (int i = 1; i < ROMLAT; i++) begin
        pvld[i] <= pvld[i-1];
        pidx[i] <= pidx[i-1];
      end
      // Every fetch rewrites all four lanes, so no clearing is needed
      // between fetches and a committed word never mixes addresses.
      if (pvld[ROMLAT-1])
        asmw[{pidx[ROMLAT-1], 3'b000} +: 8] <= bus.ROMDT;

      case (state)
        IDLE: begin
          if (grant) begin
            region <= grant_sp;
            lastbg <= !grant_sp;
            idx    <= 2'd0;
            romrd  <= 1'b1;
            romad  <= {grant_sp, (grant_sp ? bus.SPCAD : bus.BGCAD), 2'b00};
            if (!grant_sp) begin
              bglast <= bus.BGCAD;
              bgvld  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          dcnt <= 2'd0;
          if (idx == 2'd3) begin
            romrd <= 1'b0;               // romad keeps the last byte address
          end else begin
            idx        <= idx + 2'd1;
            romad[1:0] <= idx + 2'd1;    // word address field never carries
          end
        end
        DRAIN: dcnt <= dcnt + 2'd1;
        COMMIT: begin
          if (region) begin
            spcdt <= asmw;
            spcft <= 1'b1;
          end else begin
            bgcdt <= asmw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
